// File: rtl/arithmetic_circuits_full_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : full_adder                                         |
// | Description : Single-bit combinational full adder.               |
// |               s = a ^ b ^ ci, co = majority(a, b, ci).           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the odd-parity of the three inputs; carry is their majority.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule
`default_nettype wire

// File: rtl/arithmetic_circuits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : arithmetic_circuits                                |
// | Description : Single-bit full adder exposed combinationally and  |
// |               registered, plus a bit-serial adder whose carry    |
// |               register is seeded from cin when ser_en is low.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module arithmetic_circuits (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic ser_en,
  output logic sum,
  output logic cout,
  output logic sum_q,
  output logic cout_q,
  output logic ser_sum,
  output logic carry_q
);

  logic w_ser_s;
  logic w_ser_co;
  logic sum_d;
  logic cout_d;
  logic ser_sum_d;
  logic ser_sum_q;
  logic carry_d;

  // Combinational adder: depends only on x/y/cin, never on clk, rst or serial state.
  full_adder u_fa_comb (
    .a  (x),
    .b  (y),
    .ci (cin),
    .s  (sum),
    .co (cout)
  );

  // Serial-path adder: same operands but the carry comes from the carry register.
  full_adder u_fa_ser (
    .a  (x),
    .b  (y),
    .ci (carry_q),
    .s  (w_ser_s),
    .co (w_ser_co)
  );

  // Next-state: register the combinational result; serial step or reseed by ser_en.
  always_comb begin
    sum_d     = sum;
    cout_d    = cout;
    ser_sum_d = ser_sum_q;
    carry_d   = cin;
    if (ser_en) begin
      ser_sum_d = w_ser_s;
      carry_d   = w_ser_co;
    end
  end

  // All state, cleared asynchronously; a reset mid-sequence resumes from carry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= 1'b0;
      cout_q    <= 1'b0;
      ser_sum_q <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ser_sum_q <= ser_sum_d;
      carry_q   <= carry_d;
    end
  end

  assign ser_sum = ser_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_arithmetic_circuits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_arithmetic_circuits                             |
// | Description : Directed self-checking bench for the combinational,|
// |               registered and bit-serial adder paths.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_arithmetic_circuits;

  logic clk;
  logic clk_run;
  logic rst;
  logic x;
  logic y;
  logic cin;
  logic ser_en;
  logic sum;
  logic cout;
  logic sum_q;
  logic cout_q;
  logic ser_sum;
  logic carry_q;

  int n_vec;
  int n_err;

  arithmetic_circuits dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .cin     (cin),
    .ser_en  (ser_en),
    .sum     (sum),
    .cout    (cout),
    .sum_q   (sum_q),
    .cout_q  (cout_q),
    .ser_sum (ser_sum),
    .carry_q (carry_q)
  );

  // Free-running 10 ns clock that can be parked low for the idle-clock sweep.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
    else         clk = 1'b0;
  end

  // One rising edge, then settle 1 ns so sampling is away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 1'b0; y = 1'b0; cin = 1'b0; ser_en = 1'b0;
    step();
    n_vec++;
    if ({sum_q, cout_q, ser_sum, carry_q} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state: got %b want 0000", {sum_q, cout_q, ser_sum, carry_q});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_comb_sweep();
    logic [7:0] s_tab;
    logic [7:0] c_tab;
    logic [2:0] v;
    s_tab = 8'b1001_0110;
    c_tab = 8'b1110_1000;
    clk_run = 1'b0;
    #20;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {x, y, cin} = v;
      #20;
      n_vec++;
      if (sum !== s_tab[i] || cout !== c_tab[i]) begin
        n_err++;
        $display("FAIL comb_sweep[%0d]: got sum=%b cout=%b want sum=%b cout=%b",
                 i, sum, cout, s_tab[i], c_tab[i]);
      end
    end
    clk_run = 1'b1;
    step();
  endtask

  task automatic test_reg_latency();
    x = 1'b1; y = 1'b1; cin = 1'b0; ser_en = 1'b0;
    step();
    n_vec++;
    if (sum_q !== 1'b0 || cout_q !== 1'b1) begin
      n_err++;
      $display("FAIL reg_first: got sum_q=%b cout_q=%b want 0 1", sum_q, cout_q);
    end
    x = 1'b0; y = 1'b0; cin = 1'b1;
    #2;
    n_vec++;
    if (sum_q !== 1'b0 || cout_q !== 1'b1 || sum !== 1'b1 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reg_hold: got sum_q=%b cout_q=%b sum=%b cout=%b want 0 1 1 0",
               sum_q, cout_q, sum, cout);
    end
    step();
    n_vec++;
    if (sum_q !== 1'b1 || cout_q !== 1'b0) begin
      n_err++;
      $display("FAIL reg_second: got sum_q=%b cout_q=%b want 1 0", sum_q, cout_q);
    end
  endtask

  task automatic test_async_reset();
    // Drive every register to 1 first.
    ser_en = 1'b0; cin = 1'b1; x = 1'b0; y = 1'b0;
    step();
    ser_en = 1'b1; x = 1'b1; y = 1'b1; cin = 1'b1;
    step();
    n_vec++;
    if ({sum_q, cout_q, ser_sum, carry_q} !== 4'b1111) begin
      n_err++;
      $display("FAIL preload_ones: got %b want 1111", {sum_q, cout_q, ser_sum, carry_q});
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sum_q, cout_q, ser_sum, carry_q} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_clear: got %b want 0000", {sum_q, cout_q, ser_sum, carry_q});
    end
    n_vec++;
    if (sum !== 1'b1 || cout !== 1'b1) begin
      n_err++;
      $display("FAIL comb_in_reset: got sum=%b cout=%b want 1 1", sum, cout);
    end
    step();
    n_vec++;
    if ({sum_q, cout_q, ser_sum, carry_q} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: got %b want 0000", {sum_q, cout_q, ser_sum, carry_q});
    end
    rst = 1'b0;
    ser_en = 1'b0;
    step();
  endtask

  task automatic test_serial_add(input string name, input logic [3:0] a,
                                 input logic [3:0] b, input logic c,
                                 input logic [3:0] exp_bits, input logic exp_carry);
    ser_en = 1'b0; cin = c; x = 1'b0; y = 1'b0;
    step();
    n_vec++;
    if (carry_q !== c) begin
      n_err++;
      $display("FAIL %s_seed: got carry_q=%b want %b", name, carry_q, c);
    end
    cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ser_en = 1'b1; x = a[i]; y = b[i];
      step();
      n_vec++;
      if (ser_sum !== exp_bits[i]) begin
        n_err++;
        $display("FAIL %s_bit%0d: got ser_sum=%b want %b", name, i, ser_sum, exp_bits[i]);
      end
    end
    n_vec++;
    if (carry_q !== exp_carry) begin
      n_err++;
      $display("FAIL %s_carry: got carry_q=%b want %b", name, carry_q, exp_carry);
    end
    ser_en = 1'b0;
  endtask

  task automatic test_reset_mid_serial();
    // 0111 + 0101 with reset between bits 1 and 2; carry after bit 1 is 1.
    ser_en = 1'b0; cin = 1'b0; x = 1'b0; y = 1'b0;
    step();
    ser_en = 1'b1; x = 1'b1; y = 1'b1;
    step();
    x = 1'b1; y = 1'b0;
    step();
    n_vec++;
    if (carry_q !== 1'b1 || ser_sum !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pre: got carry_q=%b ser_sum=%b want 1 0", carry_q, ser_sum);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (carry_q !== 1'b0) begin
      n_err++;
      $display("FAIL mid_clear: got carry_q=%b want 0", carry_q);
    end
    rst = 1'b0;
    x = 1'b1; y = 1'b1;
    step();
    n_vec++;
    if (ser_sum !== 1'b0 || carry_q !== 1'b1) begin
      n_err++;
      $display("FAIL mid_bit2: got ser_sum=%b carry_q=%b want 0 1", ser_sum, carry_q);
    end
    x = 1'b0; y = 1'b0;
    step();
    n_vec++;
    if (ser_sum !== 1'b1 || carry_q !== 1'b0) begin
      n_err++;
      $display("FAIL mid_bit3: got ser_sum=%b carry_q=%b want 1 0", ser_sum, carry_q);
    end
    ser_en = 1'b0;
  endtask

  task automatic test_reseed();
    ser_en = 1'b0; cin = 1'b0; x = 1'b0; y = 1'b0;
    step();
    ser_en = 1'b1; x = 1'b1; y = 1'b0;
    step();
    // Reseed mid-sequence: ser_sum must hold, carry takes cin.
    ser_en = 1'b0; cin = 1'b1; x = 1'b0; y = 1'b0;
    step();
    n_vec++;
    if (ser_sum !== 1'b1 || carry_q !== 1'b1) begin
      n_err++;
      $display("FAIL reseed_hold: got ser_sum=%b carry_q=%b want 1 1", ser_sum, carry_q);
    end
    ser_en = 1'b1; cin = 1'b0;
    step();
    n_vec++;
    if (ser_sum !== 1'b1 || carry_q !== 1'b0) begin
      n_err++;
      $display("FAIL reseed_step: got ser_sum=%b carry_q=%b want 1 0", ser_sum, carry_q);
    end
    ser_en = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clk_run = 1'b1;
    rst     = 1'b1;
    x = 1'b0; y = 1'b0; cin = 1'b0; ser_en = 1'b0;
    test_reset();
    test_comb_sweep();
    test_reg_latency();
    test_async_reset();
    test_serial_add("add_7_5",  4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b0);
    test_serial_add("add_15_1", 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1);
    test_reset_mid_serial();
    test_reseed();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
